// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types, constants and helpers for the AHB-to-APB bridge
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WWAIT  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } apb_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_bridge_ctrl_if.sv
// rtl/apb_bridge_ctrl_if.sv - AHB-side and APB-side signal bundle of the bridge
interface apb_bridge_ctrl_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 3
);
    logic                  valid;
    logic [ADDR_W-1:0]     haddr;
    logic                  hwrite;
    logic [DATA_W-1:0]     hwdata;
    logic                  hreadyout;
    logic                  hresp;
    logic [DATA_W-1:0]     hrdata;
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  valid, haddr, hwrite, hwdata, prdata, pready, pslverr,
        output hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output valid, haddr, hwrite, hwdata, prdata, pready, pslverr,
        input  hreadyout, hresp, hrdata, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_sel_decode.sv
// rtl/apb_sel_decode.sv - extracts the APB slave index from haddr and flags out-of-range slaves
module apb_sel_decode
    import apb_bridge_pkg::*;
#(
    parameter int NUM_SLAVES = 3,
    parameter int SEL_LSB    = 12,
    parameter int ADDR_W     = 32,
    localparam int SEL_W     = (NUM_SLAVES <= 1) ? 1 : clog2(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] haddr,
    output logic [SEL_W-1:0]  idx,
    output logic              dec_err
);
    logic unused_haddr;

    assign idx          = haddr[SEL_LSB +: SEL_W];
    assign dec_err      = (32'(idx) >= NUM_SLAVES);
    assign unused_haddr = ^haddr;
endmodule

// File: rtl/apb_bridge_ctrl.sv
// rtl/apb_bridge_ctrl.sv - single-outstanding AHB-to-APB bridge FSM with wait states, slave errors and timeout
module apb_bridge_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 3,
    parameter int SEL_LSB    = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic                 hclk,
    input  logic                 hresetn,
    apb_bridge_ctrl_if.master    bus
);
    localparam int SEL_W = (NUM_SLAVES <= 1) ? 1 : clog2(NUM_SLAVES);
    localparam int CNT_W = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    apb_state_t        state, state_nxt;
    logic [SEL_W-1:0]  dec_idx, idx_q;
    logic              dec_err;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q, hrdata_q;
    logic              timed_out;

    apb_sel_decode #(
        .NUM_SLAVES(NUM_SLAVES),
        .SEL_LSB   (SEL_LSB),
        .ADDR_W    (ADDR_W)
    ) u_dec (
        .haddr  (bus.haddr),
        .idx    (dec_idx),
        .dec_err(dec_err)
    );

    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state    <= S_IDLE;
            idx_q    <= '0;
            cnt      <= '0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            hrdata_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (bus.valid) begin
                        paddr_q  <= bus.haddr;
                        pwrite_q <= bus.hwrite;
                        idx_q    <= dec_idx;
                    end
                end
                S_WWAIT: pwdata_q <= bus.hwdata;
                S_SETUP: cnt <= '0;
                S_ACCESS: begin
                    if (bus.pready && !bus.pslverr && !pwrite_q) begin
                        hrdata_q <= bus.prdata;
                    end
                    // Saturating so a disabled or oversized timeout never wraps.
                    if (!bus.pready && (cnt != '1)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.valid) begin
                    if (dec_err)         state_nxt = S_ERR1;
                    else if (bus.hwrite) state_nxt = S_WWAIT;
                    else                 state_nxt = S_SETUP;
                end
            end
            S_WWAIT:  state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: begin
                if (bus.pready)     state_nxt = bus.pslverr ? S_ERR1 : S_IDLE;
                else if (timed_out) state_nxt = S_ERR1;
            end
            S_ERR1:   state_nxt = S_ERR2;
            S_ERR2:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.psel      = '0;
        bus.penable   = 1'b0;
        bus.hreadyout = 1'b0;
        bus.hresp     = HRESP_OKAY;
        case (state)
            S_IDLE:   bus.hreadyout = 1'b1;
            S_SETUP:  bus.psel = NUM_SLAVES'(1) << idx_q;
            S_ACCESS: begin
                bus.psel    = NUM_SLAVES'(1) << idx_q;
                bus.penable = 1'b1;
            end
            S_ERR1:   bus.hresp = HRESP_ERROR;
            S_ERR2: begin
                bus.hresp     = HRESP_ERROR;
                bus.hreadyout = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.paddr  = paddr_q;
    assign bus.pwrite = pwrite_q;
    assign bus.pwdata = pwdata_q;
    assign bus.hrdata = hrdata_q;
endmodule

// File: tb/tb_apb_bridge_ctrl.sv
// tb/tb_apb_bridge_ctrl.sv - table-driven cycle checks of the AHB-to-APB bridge controller
module tb_apb_bridge_ctrl;

    typedef struct {
        logic        rstn;
        logic        valid;
        logic [31:0] haddr;
        logic        hwrite;
        logic [31:0] hwdata;
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
        logic        e_rdy;
        logic        e_resp;
        logic [2:0]  e_psel;
        logic        e_pen;
        logic        e_pw;
        logic [31:0] e_paddr;
        logic [31:0] e_pwdata;
        logic [31:0] e_hrdata;
    } vec_t;

    logic hclk;
    logic hresetn;
    int   checks;
    int   errors;
    int   vidx;
    vec_t tbl[$];

    apb_bridge_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NUM_SLAVES(3)) bus ();

    apb_bridge_ctrl #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .NUM_SLAVES(3),
        .SEL_LSB   (12),
        .TIMEOUT   (16)
    ) dut (
        .hclk   (hclk),
        .hresetn(hresetn),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic vec_t mk(
        input logic rstn, input logic valid, input logic [31:0] haddr, input logic hwrite,
        input logic [31:0] hwdata, input logic [31:0] prdata, input logic pready, input logic pslverr,
        input logic e_rdy, input logic e_resp, input logic [2:0] e_psel, input logic e_pen,
        input logic e_pw, input logic [31:0] e_paddr, input logic [31:0] e_pwdata, input logic [31:0] e_hrdata);
        vec_t v;
        v.rstn = rstn;     v.valid = valid;   v.haddr = haddr;       v.hwrite = hwrite;
        v.hwdata = hwdata; v.prdata = prdata; v.pready = pready;     v.pslverr = pslverr;
        v.e_rdy = e_rdy;   v.e_resp = e_resp; v.e_psel = e_psel;     v.e_pen = e_pen;
        v.e_pw = e_pw;     v.e_paddr = e_paddr; v.e_pwdata = e_pwdata; v.e_hrdata = e_hrdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, vidx, act, exp);
        end
    endtask

    // Outputs are all Moore/registered, so they are checked at the negedge where the next inputs go on.
    task automatic cycle(input vec_t v);
        @(negedge hclk);
        hresetn     = v.rstn;
        bus.valid   = v.valid;
        bus.haddr   = v.haddr;
        bus.hwrite  = v.hwrite;
        bus.hwdata  = v.hwdata;
        bus.prdata  = v.prdata;
        bus.pready  = v.pready;
        bus.pslverr = v.pslverr;
        check("hreadyout", 64'(bus.hreadyout), 64'(v.e_rdy));
        check("hresp",     64'(bus.hresp),     64'(v.e_resp));
        check("psel",      64'(bus.psel),      64'(v.e_psel));
        check("penable",   64'(bus.penable),   64'(v.e_pen));
        check("pwrite",    64'(bus.pwrite),    64'(v.e_pw));
        check("paddr",     64'(bus.paddr),     64'(v.e_paddr));
        check("pwdata",    64'(bus.pwdata),    64'(v.e_pwdata));
        check("hrdata",    64'(bus.hrdata),    64'(v.e_hrdata));
        vidx++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vidx   = 0;
        hresetn = 1'b0;
        bus.valid = 1'b0; bus.haddr = '0; bus.hwrite = 1'b0; bus.hwdata = '0;
        bus.prdata = '0;  bus.pready = 1'b0; bus.pslverr = 1'b0;

        //            rst vld haddr         wr hwdata        prdata        rdy err | rdy rsp psel   pen pw paddr         pwdata        hrdata
        // reset state
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   1, 0, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0));
        // zero-wait read of slave 1
        tbl.push_back(mk(1, 1, 32'h0000_1004, 0, 32'h0,        32'hCAFE_F00D, 1, 0,  1, 0, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'hCAFE_F00D, 1, 0,  0, 0, 3'b010, 0, 0, 32'h0000_1004, 32'h0,       32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'hCAFE_F00D, 1, 0,  0, 0, 3'b010, 1, 0, 32'h0000_1004, 32'h0,       32'h0));
        // back-to-back write to slave 2 with 3 wait states
        tbl.push_back(mk(1, 1, 32'h0000_2010, 1, 32'h0,        32'h0,        0, 0,   1, 0, 3'b000, 0, 0, 32'h0000_1004, 32'h0,        32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h1234_5678, 32'h0,       0, 0,   0, 0, 3'b000, 0, 1, 32'h0000_2010, 32'h0,        32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   0, 0, 3'b100, 0, 1, 32'h0000_2010, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   0, 0, 3'b100, 1, 1, 32'h0000_2010, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   0, 0, 3'b100, 1, 1, 32'h0000_2010, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   0, 0, 3'b100, 1, 1, 32'h0000_2010, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        1, 0,   0, 0, 3'b100, 1, 1, 32'h0000_2010, 32'h1234_5678, 32'hCAFE_F00D));
        // read of slave 0 answered with pslverr; valid in ERR2 must be ignored
        tbl.push_back(mk(1, 1, 32'h0000_0000, 0, 32'h0,        32'h0,        0, 0,   1, 0, 3'b000, 0, 1, 32'h0000_2010, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'hDEAD_BEEF, 1, 1,  0, 0, 3'b001, 0, 0, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'hDEAD_BEEF, 1, 1,  0, 0, 3'b001, 1, 0, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   0, 1, 3'b000, 0, 0, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 1, 32'h0000_1000, 0, 32'h0,        32'h0,        0, 0,   1, 1, 3'b000, 0, 0, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D));
        // out-of-range slave index 3
        tbl.push_back(mk(1, 1, 32'h0000_3000, 1, 32'h0,        32'h0,        0, 0,   1, 0, 3'b000, 0, 0, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'hAAAA_5555, 32'h0,       1, 0,   0, 1, 3'b000, 0, 1, 32'h0000_3000, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        1, 0,   1, 1, 3'b000, 0, 1, 32'h0000_3000, 32'h1234_5678, 32'hCAFE_F00D));
        // write then read, reset during the read's ACCESS
        tbl.push_back(mk(1, 1, 32'h0000_0008, 1, 32'h0,        32'h0,        0, 0,   1, 0, 3'b000, 0, 1, 32'h0000_3000, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0BAD_F00D, 32'h0,       1, 0,   0, 0, 3'b000, 0, 1, 32'h0000_0008, 32'h1234_5678, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        1, 0,   0, 0, 3'b001, 0, 1, 32'h0000_0008, 32'h0BAD_F00D, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 1, 32'h0000_1020, 0, 32'h0,        32'h0,        1, 0,   0, 0, 3'b001, 1, 1, 32'h0000_0008, 32'h0BAD_F00D, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 1, 32'h0000_1020, 0, 32'h0,        32'h0,        0, 0,   1, 0, 3'b000, 0, 1, 32'h0000_0008, 32'h0BAD_F00D, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   0, 0, 3'b010, 0, 0, 32'h0000_1020, 32'h0BAD_F00D, 32'hCAFE_F00D));
        tbl.push_back(mk(0, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   0, 0, 3'b010, 1, 0, 32'h0000_1020, 32'h0BAD_F00D, 32'hCAFE_F00D));
        tbl.push_back(mk(1, 1, 32'h0000_1000, 0, 32'h0,        32'h5A5A_5A5A, 1, 0,  1, 0, 3'b000, 0, 0, 32'h0,        32'h0,        32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h5A5A_5A5A, 1, 0,  0, 0, 3'b010, 0, 0, 32'h0000_1000, 32'h0,       32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h5A5A_5A5A, 1, 0,  0, 0, 3'b010, 1, 0, 32'h0000_1000, 32'h0,       32'h0));
        tbl.push_back(mk(1, 0, 32'h0,         0, 32'h0,        32'h0,        0, 0,   1, 0, 3'b000, 0, 0, 32'h0000_1000, 32'h0,        32'h5A5A_5A5A));

        repeat (2) @(posedge hclk);
        foreach (tbl[i]) cycle(tbl[i]);

        // timeout: 16 ACCESS cycles without pready end in ERR1/ERR2
        cycle(mk(1, 1, 32'h0000_2000, 0, 32'h0, 32'h0, 0, 0,  1, 0, 3'b000, 0, 0, 32'h0000_1000, 32'h0, 32'h5A5A_5A5A));
        cycle(mk(1, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0,  0, 0, 3'b100, 0, 0, 32'h0000_2000, 32'h0, 32'h5A5A_5A5A));
        for (int i = 0; i < 16; i++)
            cycle(mk(1, 0, 32'h0, 0, 32'h0, 32'h1111_2222, 0, 0,  0, 0, 3'b100, 1, 0, 32'h0000_2000, 32'h0, 32'h5A5A_5A5A));
        cycle(mk(1, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0,  0, 1, 3'b000, 0, 0, 32'h0000_2000, 32'h0, 32'h5A5A_5A5A));
        cycle(mk(1, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0,  1, 1, 3'b000, 0, 0, 32'h0000_2000, 32'h0, 32'h5A5A_5A5A));

        // pready on the threshold cycle wins over the timeout
        cycle(mk(1, 1, 32'h0000_2000, 0, 32'h0, 32'h0, 0, 0,  1, 0, 3'b000, 0, 0, 32'h0000_2000, 32'h0, 32'h5A5A_5A5A));
        cycle(mk(1, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0,  0, 0, 3'b100, 0, 0, 32'h0000_2000, 32'h0, 32'h5A5A_5A5A));
        for (int i = 0; i < 15; i++)
            cycle(mk(1, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0,  0, 0, 3'b100, 1, 0, 32'h0000_2000, 32'h0, 32'h5A5A_5A5A));
        cycle(mk(1, 0, 32'h0,         0, 32'h0, 32'h7777_8888, 1, 0,  0, 0, 3'b100, 1, 0, 32'h0000_2000, 32'h0, 32'h5A5A_5A5A));
        cycle(mk(1, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0,  1, 0, 3'b000, 0, 0, 32'h0000_2000, 32'h0, 32'h7777_8888));
        cycle(mk(1, 0, 32'h0,         0, 32'h0, 32'h0, 0, 0,  1, 0, 3'b000, 0, 0, 32'h0000_2000, 32'h0, 32'h7777_8888));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
